add_m: RTL and testbench



---
 rtl/add_m.sv | 95 +++++++++
 tb/tb_add_m.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_m.sv
// Sequential 3x3 matrix adder: C = A + B element-wise, one element per clock,
// with operands captured on start so the caller may change A/B while busy.
module add_m #(
    parameter int DATA_W = 32,
    parameter int N      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] A [0:N-1],
    input  logic [DATA_W-1:0] B [0:N-1],
    output logic [DATA_W-1:0] C [0:N-1],
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] aq_q [0:N-1];
    logic [DATA_W-1:0] bq_q [0:N-1];
    logic [DATA_W-1:0] c_q  [0:N-1];
    logic              load;
    logic              write;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                write = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < N; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Sum keeps only DATA_W bits: carry out is discarded (modulo 2^DATA_W).
            if (write) begin
                c_q[idx_q] <= aq_q[idx_q] + bq_q[idx_q];
            end
        end
    end

    // Operand registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) begin
                aq_q[i] <= A[i];
                bq_q[i] <= B[i];
            end
        end
    end

    assign C    = c_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_add_m.sv
// Directed bench for add_m: reset, sums, wrap-around, operand latching,
// ignored starts, mid-run reset and back-to-back operation.
module tb_add_m;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a [0:8];
    logic [31:0] b [0:8];
    logic [31:0] c [0:8];
    logic        busy;
    logic        done;

    int total;
    int bad;

    add_m #(.DATA_W(32), .N(9)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (a),
        .B     (b),
        .C     (c),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen or the budget runs out; edges = edges consumed.
    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            tick();
            edges++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'hDEAD_0000 + i;
            b[i] = 32'h0000_BEEF;
        end
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_c[%0d]: got %h want 0", i, c[i]);
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'(i + 1);
            b[i] = 32'(9 - i);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_run_cycle%0d: busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
            tick();
            if (k == 1) begin
                total++;
                if (c[0] !== 32'd10 || c[1] !== 32'd0) begin
                    bad++;
                    $display("FAIL basic_partial: c0=%0d c1=%0d want 10 0", c[0], c[1]);
                end
            end
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL basic_done: busy=%b done=%b want busy=0 done=1", busy, done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'd10) begin
                bad++;
                $display("FAIL basic_c[%0d]: got %0d want 10", i, c[i]);
            end
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_after: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_overflow();
        int edges;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'hFFFF_FFFF;
            b[i] = 32'd2;
        end
        a[4] = 32'h8000_0000;
        b[4] = 32'h8000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, edges);
        total++;
        if (edges !== 9 || done !== 1'b1) begin
            bad++;
            $display("FAIL ovf_latency: edges=%0d done=%b want 9 1", edges, done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== ((i == 4) ? 32'd0 : 32'd1)) begin
                bad++;
                $display("FAIL ovf_c[%0d]: got %h want %h", i, c[i], (i == 4) ? 32'd0 : 32'd1);
            end
        end
        tick();
    endtask

    task automatic test_latch();
        int edges;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'd5;
            b[i] = 32'd7;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) a[i] = 32'd100;
        wait_done(20, edges);
        total++;
        if (edges !== 8 || done !== 1'b1) begin
            bad++;
            $display("FAIL latch_latency: edges=%0d done=%b want 8 1", edges, done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'd12) begin
                bad++;
                $display("FAIL latch_c[%0d]: got %0d want 12", i, c[i]);
            end
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        int done_at;
        int busy_cycles;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'(i + 1);
            b[i] = 32'(9 - i);
        end
        start = 1'b1;
        tick();
        pulses      = 0;
        done_at     = 0;
        busy_cycles = 1;
        for (int t = 1; t <= 20; t++) begin
            start = (t == 3 || t == 9);
            tick();
            if (done) begin
                pulses++;
                done_at = t;
            end
            if (busy) busy_cycles++;
            if (busy && done) begin
                total++;
                bad++;
                $display("FAIL ign_overlap: busy and done both high at t=%0d", t);
            end
        end
        start = 1'b0;
        total++;
        if (pulses !== 1 || done_at !== 9) begin
            bad++;
            $display("FAIL ign_pulses: pulses=%0d at=%0d want 1 at 9", pulses, done_at);
        end
        total++;
        if (busy_cycles !== 9) begin
            bad++;
            $display("FAIL ign_busy_cycles: got %0d want 9", busy_cycles);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'd10) begin
                bad++;
                $display("FAIL ign_c[%0d]: got %0d want 10", i, c[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int edges;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'(i);
            b[i] = 32'd20;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rmid_ctrl: busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'd0) begin
                bad++;
                $display("FAIL rmid_c[%0d]: got %0d want 0", i, c[i]);
            end
        end
        pulses = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (done || busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL rmid_activity: got %0d active cycles want 0", pulses);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, edges);
        total++;
        if (edges !== 9 || done !== 1'b1) begin
            bad++;
            $display("FAIL rmid_restart_latency: edges=%0d done=%b want 9 1", edges, done);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (c[i] !== 32'(i + 20)) begin
                bad++;
                $display("FAIL rmid_restart_c[%0d]: got %0d want %0d", i, c[i], i + 20);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int first_at;
        int second_at;
        for (int i = 0; i < 9; i++) begin
            a[i] = 32'd1;
            b[i] = 32'd1;
        end
        first_at  = -1;
        second_at = -1;
        start = 1'b1;
        tick();
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (done) begin
                if (first_at < 0) begin
                    first_at = t;
                    for (int i = 0; i < 9; i++) begin
                        total++;
                        if (c[i] !== 32'd2) begin
                            bad++;
                            $display("FAIL b2b_first_c[%0d]: got %0d want 2", i, c[i]);
                        end
                        a[i] = 32'd3;
                        b[i] = 32'd4;
                    end
                end else begin
                    second_at = t;
                    start = 1'b0;
                    for (int i = 0; i < 9; i++) begin
                        total++;
                        if (c[i] !== 32'd7) begin
                            bad++;
                            $display("FAIL b2b_second_c[%0d]: got %0d want 7", i, c[i]);
                        end
                    end
                    break;
                end
            end
        end
        start = 1'b0;
        total++;
        if (first_at !== 9 || second_at !== 20) begin
            bad++;
            $display("FAIL b2b_timing: first=%0d second=%0d want 9 20", first_at, second_at);
        end
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_latch();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
